// File: rtl/noc_mesh_router.sv
// Five-port input-buffered mesh router: XY routing, per-output round-robin
// arbitration, credit-based flow control and sticky input overflow flags.
module noc_mesh_router #(
  parameter int DATA_W    = 16,
  parameter int COORD_W   = 2,
  parameter int BUF_DEPTH = 4,
  parameter int X_POS     = 0,
  parameter int Y_POS     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          valid_i,
  input  logic [5*DATA_W-1:0] data_i,
  output logic [4:0]          credit_o,
  output logic [4:0]          valid_o,
  output logic [5*DATA_W-1:0] data_o,
  input  logic [4:0]          credit_i,
  output logic [4:0]          overflow_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0]      FULL = CW'(BUF_DEPTH);
  localparam logic [COORD_W-1:0] XP   = COORD_W'(X_POS);
  localparam logic [COORD_W-1:0] YP   = COORD_W'(Y_POS);

  logic [DATA_W-1:0]  mem [5][BUF_DEPTH];
  logic [PW-1:0]      rd_ptr [5];
  logic [PW-1:0]      wr_ptr [5];
  logic [CW-1:0]      fill [5];
  logic [CW-1:0]      cnt [5];
  logic [2:0]         rr [5];
  logic [DATA_W-1:0]  head [5];
  logic [COORD_W-1:0] dest_x [5];
  logic [COORD_W-1:0] dest_y [5];
  logic [2:0]         route [5];
  logic [4:0]         req [5];
  logic [4:0]         gnt [5];
  logic [2:0]         gsel [5];
  logic [4:0]         pop, push, send;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      head[i]   = mem[i][rd_ptr[i]];
      dest_x[i] = head[i][DATA_W-1 -: COORD_W];
      dest_y[i] = head[i][DATA_W-1-COORD_W -: COORD_W];
      if (dest_x[i] > XP)      route[i] = 3'd2;
      else if (dest_x[i] < XP) route[i] = 3'd4;
      else if (dest_y[i] > YP) route[i] = 3'd3;
      else if (dest_y[i] < YP) route[i] = 3'd1;
      else                     route[i] = 3'd0;
      req[i] = (fill[i] != '0) ? (5'b00001 << route[i]) : 5'b00000;
    end
  end

  // Round-robin search from rr[o]; only outputs holding credit may grant.
  always_comb begin
    logic [3:0] s;
    logic [2:0] idx;
    logic       found;
    pop   = '0;
    send  = '0;
    s     = '0;
    idx   = '0;
    found = 1'b0;
    for (int o = 0; o < 5; o++) begin
      gnt[o]  = '0;
      gsel[o] = '0;
      found   = 1'b0;
      for (int k = 0; k < 5; k++) begin
        s   = {1'b0, rr[o]} + 4'(k);
        idx = (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
        if (!found && req[idx][o] && cnt[o] != '0) begin
          found       = 1'b1;
          gnt[o][idx] = 1'b1;
          gsel[o]     = idx;
        end
      end
      send[o] = |gnt[o];
      pop     = pop | gnt[o];
    end
    for (int p = 0; p < 5; p++)
      push[p] = valid_i[p] && (fill[p] != FULL || pop[p]);
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++)
      if (push[p]) mem[p][wr_ptr[p]] <= data_i[p*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        fill[p]   <= '0;
        cnt[p]    <= FULL;
        rr[p]     <= '0;
      end
      valid_o    <= '0;
      credit_o   <= '0;
      data_o     <= '0;
      overflow_o <= '0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        if (push[p] && !pop[p])      fill[p] <= fill[p] + 1'b1;
        else if (!push[p] && pop[p]) fill[p] <= fill[p] - 1'b1;
        if (valid_i[p] && !push[p]) overflow_o[p] <= 1'b1;
      end
      for (int o = 0; o < 5; o++) begin
        if (send[o] && !credit_i[o])                     cnt[o] <= cnt[o] - 1'b1;
        else if (!send[o] && credit_i[o] && cnt[o] != FULL) cnt[o] <= cnt[o] + 1'b1;
        if (send[o]) begin
          rr[o] <= (gsel[o] == 3'd4) ? 3'd0 : gsel[o] + 3'd1;
          data_o[o*DATA_W +: DATA_W] <= head[gsel[o]];
        end
      end
      valid_o  <= send;
      credit_o <= pop;
    end
  end

endmodule

// File: tb/tb_noc_mesh_router.sv
// Bench for noc_mesh_router at tile (1,1): routing table, round-robin,
// credit exhaustion, overflow and reset-in-flight sequences.
module tb_noc_mesh_router;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    valid_i, credit_o, valid_o, credit_i, overflow_o;
  logic [4:0]    auto_mask, man_credit;
  logic [5*DW-1:0] data_i, data_o;

  always #5 clk = ~clk;

  // Downstream model returns a credit for each flit it sees when enabled.
  assign credit_i = (auto_mask & valid_o) | man_credit;

  noc_mesh_router #(.DATA_W(16), .COORD_W(2), .BUF_DEPTH(4), .X_POS(1), .Y_POS(1)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .credit_o(credit_o),
    .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i), .overflow_o(overflow_o)
  );

  typedef struct {int port; logic [15:0] data;} exp_t;
  typedef struct {logic [1:0] dx; logic [1:0] dy; int port;} vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   rx_count [5] = '{default: 0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mkflit(logic [1:0] dx, logic [1:0] dy, logic [11:0] pl);
    return {dx, dy, pl};
  endfunction

  always @(negedge clk) begin
    for (int o = 0; o < 5; o++) begin
      if (valid_o[o] === 1'b1) begin
        int idx;
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].port == o) idx = k;
        checks++;
        rx_count[o]++;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_flit port %0d: got %h expected none", o, data_o[o*DW +: DW]);
        end else begin
          if (data_o[o*DW +: DW] !== sb[idx].data) begin
            errors++;
            $display("FAIL flit_data port %0d: got %h expected %h", o, data_o[o*DW +: DW], sb[idx].data);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic idle(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send1(int p, logic [15:0] f);
    valid_i = 5'b00001 << p;
    data_i[p*DW +: DW] = f;
    @(negedge clk);
    valid_i = '0;
  endtask

  task automatic do_reset();
    valid_i = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_credit(int p, int n);
    man_credit[p] = 1'b1;
    idle(n);
    man_credit[p] = 1'b0;
  endtask

  vec_t        vecs [5];
  logic [15:0] f;
  logic [13:0] hist;
  int          base;
  logic        quiet;

  initial begin
    rst = 1'b1; valid_i = '0; data_i = '0; auto_mask = 5'b11111; man_credit = '0;
    idle(2);
    rst = 1'b0;
    check("reset_valid_o", valid_o, 0);
    check("reset_credit_o", credit_o, 0);
    check("reset_data_o", |data_o, 0);
    check("reset_overflow_o", overflow_o, 0);

    // Loopback plus XY routing from the Local input
    vecs[0] = '{2'd1, 2'd1, 0};
    vecs[1] = '{2'd3, 2'd0, 2};
    vecs[2] = '{2'd0, 2'd2, 4};
    vecs[3] = '{2'd1, 2'd0, 1};
    vecs[4] = '{2'd1, 2'd3, 3};
    for (int v = 0; v < 5; v++) begin
      f = mkflit(vecs[v].dx, vecs[v].dy, 12'h100 + 12'(v));
      sb.push_back('{vecs[v].port, f});
      send1(0, f);
      check("route_cycle1_idle", valid_o, 0);
      @(negedge clk);
      check("route_cycle2_valid", valid_o, 32'(1) << vecs[v].port);
      check("route_cycle2_credit", credit_o, 5'b00001);
      @(negedge clk);
      check("route_cycle3_idle", valid_o, 0);
    end

    // Round-robin: inputs 1..3 each deliver 3 flits to Local
    do_reset();
    for (int s = 0; s < 3; s++)
      for (int i = 1; i < 4; i++)
        sb.push_back('{0, mkflit(2'd1, 2'd1, 12'(i*16 + s))});
    valid_i = 5'b01110;
    for (int i = 1; i < 4; i++) data_i[i*DW +: DW] = mkflit(2'd1, 2'd1, 12'(i*16));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      hist[c] = valid_o[0];
      if (c < 2) begin
        for (int i = 1; i < 4; i++) data_i[i*DW +: DW] = mkflit(2'd1, 2'd1, 12'(i*16 + c + 1));
      end else begin
        valid_i = '0;
      end
    end
    check("rr_nine_consecutive", hist, 14'h03FE);
    check("rr_all_delivered", sb.size(), 0);

    // Credit exhaustion on East
    do_reset();
    auto_mask[2] = 1'b0;
    base = rx_count[2];
    for (int j = 0; j < 8; j++) sb.push_back('{2, mkflit(2'd3, 2'd1, 12'h200 + 12'(j))});
    for (int j = 0; j < 6; j++) send1(0, mkflit(2'd3, 2'd1, 12'h200 + 12'(j)));
    idle(8);
    check("credit_stall_after_4", rx_count[2] - base, 4);
    pulse_credit(2, 1);
    idle(6);
    check("credit_one_more", rx_count[2] - base, 5);
    send1(0, mkflit(2'd3, 2'd1, 12'h206));
    send1(0, mkflit(2'd3, 2'd1, 12'h207));
    idle(4);
    check("credit_still_stalled", rx_count[2] - base, 5);
    pulse_credit(2, 2);
    idle(8);
    check("credit_send_and_return", rx_count[2] - base, 7);
    pulse_credit(2, 1);
    idle(6);
    check("credit_last_flit", rx_count[2] - base, 8);
    check("credit_sb_empty", sb.size(), 0);

    // Overflow on West input while East is out of credit
    do_reset();
    auto_mask[2] = 1'b0;
    base = rx_count[2];
    for (int j = 0; j < 4; j++) begin
      f = mkflit(2'd3, 2'd1, 12'h300 + 12'(j));
      sb.push_back('{2, f});
      send1(0, f);
    end
    idle(6);
    check("ovf_east_drained", rx_count[2] - base, 4);
    check("ovf_clear_before", overflow_o, 0);
    for (int j = 0; j < 5; j++) send1(4, mkflit(2'd3, 2'd1, 12'h400 + 12'(j)));
    idle(1);
    check("ovf_set", overflow_o, 5'b10000);
    idle(4);
    check("ovf_sticky", overflow_o, 5'b10000);
    do_reset();
    check("ovf_cleared_by_reset", overflow_o, 0);
    auto_mask = 5'b11111;
    idle(8);
    check("ovf_fifo_emptied", rx_count[2] - base, 4);

    // Reset with flits buffered
    do_reset();
    auto_mask[2] = 1'b0;
    base = rx_count[2];
    for (int j = 0; j < 7; j++) begin
      f = mkflit(2'd3, 2'd1, 12'h500 + 12'(j));
      if (j < 4) sb.push_back('{2, f});
      send1(0, f);
    end
    idle(3);
    check("flight_first_four", rx_count[2] - base, 4);
    do_reset();
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (valid_o !== 5'b0 || credit_o !== 5'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("flight_quiet_after_reset", quiet, 1);
    base = rx_count[2];
    f = mkflit(2'd3, 2'd1, 12'h600);
    sb.push_back('{2, f});
    send1(0, f);
    check("flight_new_cycle1_idle", valid_o, 0);
    @(negedge clk);
    check("flight_new_cycle2_valid", valid_o, 5'b00100);
    check("flight_new_cycle2_credit", credit_o, 5'b00001);
    for (int j = 1; j < 5; j++) begin
      f = mkflit(2'd3, 2'd1, 12'h600 + 12'(j));
      if (j < 4) sb.push_back('{2, f});
      send1(0, f);
    end
    idle(6);
    check("flight_credit_restored", rx_count[2] - base, 4);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/noc_mesh_router.md
# noc_mesh_router

Parametrised 5-port, input-buffered, credit-flow-controlled router node for the 2D mesh NoC; one instance per mesh tile. Flits are single-flit packets carrying destination coordinates. They are routed dimension-order (X then Y), arbitrated round-robin per output port, and forwarded with registered outputs. The block generalises the fixed 4x4/16-bit valid/credit/data link to configurable data width, coordinate width, buffer depth and tile position, and adds sticky overflow reporting.

## Interface
Parameters:
- DATA_W, 16, flit width in bits; must be ≥ 2*COORD_W+1
- COORD_W, 2, bits per coordinate (mesh up to 2^COORD_W per side)
- BUF_DEPTH, 4, input FIFO depth per port; power of two, ≥2; also the initial credit count per output
- X_POS, 0, this tile's X coordinate
- Y_POS, 0, this tile's Y coordinate

Port index: 0 = Local, 1 = North, 2 = East, 3 = South, 4 = West. Vectors are packed; port p occupies bit p or slice [p*DATA_W +: DATA_W].

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  5  flit present on input p
- data_i  in  5*DATA_W  input flits; dest_x = flit[DATA_W-1 -: COORD_W], dest_y = flit[DATA_W-1-COORD_W -: COORD_W]
- credit_o  out  5  one-cycle pulse: one slot freed in input FIFO p
- valid_o  out  5  flit present on output p
- data_o  out  5*DATA_W  output flits, unmodified payload
- credit_i  in  5  one-cycle pulse: downstream freed one slot for output p
- overflow_o  out  5  sticky: flit arrived on full input FIFO p

## Operation
- Input: valid_i[p] high at an edge writes data_i[p] into FIFO p. If FIFO p is full, the flit is dropped, overflow_o[p] sets, and the FIFO is unchanged.
- Route (combinational on each non-empty FIFO head), comparisons unsigned:
  - dest_x > X_POS → East
  - dest_x < X_POS → West
  - else dest_y > Y_POS → South
  - dest_y < Y_POS → North
  - else Local
- No U-turn suppression; the computed port is always used.
- Output credit counter cnt[o], width $clog2(BUF_DEPTH+1), reset to BUF_DEPTH:
  - −1 on send
  - +1 on credit_i[o]
  - both in the same cycle → unchanged
  - credit_i when cnt = BUF_DEPTH is ignored (saturates)
- Arbitration per output o: candidates are inputs whose head routes to o. A grant requires cnt[o] > 0.
  - Round-robin starting from rr[o], searching upward and wrapping 4→0.
  - After a grant to input g, rr[o] ← (g+1) mod 5; otherwise rr[o] holds.
- Each input head requests exactly one output, so each FIFO pops at most one flit per cycle.
- Grant at edge E:
  - The FIFO pops.
  - data_o[o]/valid_o[o] are registered, high for exactly the cycle after E.
  - credit_o[g] is registered, high for the cycle after E.
- valid_o[o] is low in any cycle with no grant; data_o holds its last value when invalid.
- Simultaneous write and pop on the same FIFO are both performed. A write to a full FIFO that pops in the same cycle is accepted (no overflow).
- The upstream protocol guarantees no overflow; overflow_o exists only for error detection.

## Timing
- Reset (rst high at an edge):
  - valid_o = 0, credit_o = 0, data_o = 0, overflow_o = 0
  - FIFOs empty, cnt[*] = BUF_DEPTH, rr[*] = 0
- Reset mid-operation discards all buffered flits; no credit_o pulses are issued for them.
- Inputs are ignored in the reset cycle.
- Latency: flit sampled at edge E0 into an empty FIFO with credit available → valid_o high in the cycle after edge E0+1 (2 cycles). credit_o is high in the same cycle as that valid_o.
- Throughput: 1 flit/cycle/output sustained while cnt[o] > 0.
- Without credit_i, a port sends at most BUF_DEPTH flits.
- FIFO pointers are $clog2(BUF_DEPTH) wide and wrap. Full/empty are distinguished by an extra occupancy bit or counter.

## Test plan
- Local loopback: X_POS = Y_POS = 1, flit dest (1,1) on input 0 at edge 0 → valid_o[0] high in cycle 2 with the same data, credit_o[0] pulse in cycle 2.
- XY routing: at tile (1,1), inject dest (3,0), (0,2), (1,0), (1,3) on Local → outputs East, West, North, South respectively, each after 2 cycles.
- Round-robin: inputs 1, 2, 3 each hold 3 flits to Local → grant order 1, 2, 3, 1, 2, 3, 1, 2, 3; valid_o[0] high 9 consecutive cycles.
- Credit exhaustion: BUF_DEPTH = 4, send 6 flits to East with credit_i low → exactly 4 valid_o[2] pulses then stall. One credit_i pulse → exactly one more flit. A simultaneous send and credit_i leaves cnt unchanged.
- Overflow: hold East blocked (cnt = 0), push 5 flits into input 4 → 5th dropped, overflow_o[4] = 1 and stays set. After rst, overflow_o = 0 and the FIFO is empty.
- Reset mid-flight: 3 flits buffered, assert rst → no valid_o or credit_o after reset, cnt = BUF_DEPTH. A new flit is forwarded with 2-cycle latency.
